// File: rtl/sched_pkg.sv
// Shared opcode constants, scheduler states and the per-slot decoded-instruction
// record used by the dual-issue scheduler and its slot decoders.
package sched_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BR_WAIT,
        FLUSH
    } sched_state_e;

    // uses_rs1/uses_rs2/writes_rd are already cleared for x0, so consumers
    // never need to special-case register zero.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       writes_rd;
        logic       is_mem;
        logic       is_load;
        logic       is_ctrl;
    } dec_t;

    function automatic logic readsReg(input dec_t d, input logic [4:0] r);
        return (d.uses_rs1 && (d.rs1 == r)) || (d.uses_rs2 && (d.rs2 == r));
    endfunction

endpackage

// File: rtl/ins_class_decode.sv
// Combinational operand/class decoder for one issue slot; unknown opcodes
// decode as a NOP that reads and writes nothing.
module ins_class_decode
    import sched_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] instr_i,
    output dec_t            dec_o
);

    logic [6:0] opcode;
    logic       rdRs1;
    logic       rdRs2;
    logic       wrRd;
    logic       unusedBits;

    assign opcode     = instr_i[6:0];
    assign unusedBits = ^{instr_i[XLEN-1:25], instr_i[14:12]};

    always_comb begin
        rdRs1        = 1'b0;
        rdRs2        = 1'b0;
        wrRd         = 1'b0;
        dec_o        = '0;
        unique case (opcode)
            OPC_R: begin
                rdRs1 = 1'b1;
                rdRs2 = 1'b1;
                wrRd  = 1'b1;
            end
            OPC_IMM, OPC_LOAD, OPC_JALR: begin
                rdRs1 = 1'b1;
                wrRd  = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                rdRs1 = 1'b1;
                rdRs2 = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                wrRd = 1'b1;
            end
            default: ;
        endcase

        dec_o.rs1       = instr_i[19:15];
        dec_o.rs2       = instr_i[24:20];
        dec_o.rd        = instr_i[11:7];
        dec_o.uses_rs1  = rdRs1 && (instr_i[19:15] != 5'd0);
        dec_o.uses_rs2  = rdRs2 && (instr_i[24:20] != 5'd0);
        dec_o.writes_rd = wrRd  && (instr_i[11:7]  != 5'd0);
        dec_o.is_load   = (opcode == OPC_LOAD);
        dec_o.is_mem    = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
        dec_o.is_ctrl   = (opcode == OPC_BRANCH) || (opcode == OPC_JAL) ||
                          (opcode == OPC_JALR);
    end

endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order 0/1/2-wide issue controller: pair hazard checks, a one-entry load
// scoreboard and a branch wait/flush sequence.
module dual_issue_scheduler
    import sched_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LOAD_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instruction0,
    input  logic [XLEN-1:0] instruction1,
    input  logic            ins0_valid,
    input  logic            ins1_valid,
    input  logic            branch_resolved,
    input  logic            branch_taken,
    output logic            datapath_1_enable,
    output logic            datapath_2_enable,
    output logic            freeze1,
    output logic            freeze2,
    output logic [1:0]      consume,
    output logic            flush,
    output logic            load_busy
);

    sched_state_e state_q;
    logic [2:0]   loadCnt_q;
    logic [4:0]   loadRd_q;
    dec_t         dec0;
    dec_t         dec1;
    logic         loadPending;
    logic         hazard0;
    logic         hazard1;
    logic         pairOk;

    ins_class_decode #(.XLEN(XLEN)) uDecode0 (.instr_i(instruction0), .dec_o(dec0));
    ins_class_decode #(.XLEN(XLEN)) uDecode1 (.instr_i(instruction1), .dec_o(dec1));

    assign loadPending = (loadCnt_q != 3'd0);
    assign hazard0 = loadPending && (readsReg(dec0, loadRd_q) || dec0.is_load);
    assign hazard1 = loadPending && (readsReg(dec1, loadRd_q) || dec1.is_load);

    // Slot 1 may only pair with a non-control slot 0 and must stay off the
    // memory port and PC, which belong to datapath 1.
    assign pairOk = ins1_valid && !dec0.is_ctrl && !dec1.is_mem && !dec1.is_ctrl &&
                    !(dec0.writes_rd && readsReg(dec1, dec0.rd)) &&
                    !(dec0.writes_rd && dec1.writes_rd && (dec0.rd == dec1.rd)) &&
                    !hazard1;

    always_comb begin
        datapath_1_enable = 1'b0;
        datapath_2_enable = 1'b0;
        flush             = 1'b0;
        if (state_q == ISSUE) begin
            datapath_1_enable = ins0_valid && !hazard0;
            datapath_2_enable = datapath_1_enable && pairOk;
        end
        if (state_q == FLUSH) begin
            flush = 1'b1;
        end
    end

    assign freeze1   = !datapath_1_enable;
    assign freeze2   = !datapath_2_enable;
    assign consume   = {1'b0, datapath_1_enable} + {1'b0, datapath_2_enable};
    assign load_busy = (state_q != IDLE) && loadPending;

    // Loads in flight are older than any branch, so FLUSH leaves the counter alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            loadCnt_q <= 3'd0;
            loadRd_q  <= 5'd0;
        end else begin
            if (datapath_1_enable && dec0.is_load) begin
                loadCnt_q <= 3'(LOAD_LAT);
                loadRd_q  <= dec0.rd;
            end else if (loadPending) begin
                loadCnt_q <= loadCnt_q - 3'd1;
            end

            unique case (state_q)
                IDLE:    state_q <= ISSUE;
                ISSUE:   if (datapath_1_enable && dec0.is_ctrl) state_q <= BR_WAIT;
                BR_WAIT: if (branch_resolved) state_q <= branch_taken ? FLUSH : ISSUE;
                FLUSH:   state_q <= ISSUE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
- In-order issue controller for the dual-datapath core.
- Each cycle it inspects the two oldest fetched instructions and decides how many issue: 0, 1 or 2.
- Drives datapath_1_enable and datapath_2_enable, the per-slot freeze signals back to fetch, and a flush on a taken branch.
- Tracks one in-flight load and one unresolved control-flow instruction.

Parameters:
XLEN, 32, instruction width
LOAD_LAT, 2, cycles a load's rd stays unavailable after issue (1..7)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
instruction0  in  XLEN  oldest fetched instruction (slot 0)
instruction1  in  XLEN  next instruction (slot 1)
ins0_valid  in  1  slot 0 holds a real instruction
ins1_valid  in  1  slot 1 holds a real instruction
branch_resolved  in  1  datapath 1 has resolved the outstanding control instruction
branch_taken  in  1  qualifies branch_resolved; redirect required
datapath_1_enable  out  1  slot 0 issues to datapath 1 this cycle
datapath_2_enable  out  1  slot 1 issues to datapath 2 this cycle
freeze1  out  1  slot 0 held in fetch buffer
freeze2  out  1  slot 1 held in fetch buffer
consume  out  2  instructions retired from the fetch buffer this cycle (0..2)
flush  out  1  discard fetch buffer contents
load_busy  out  1  load counter nonzero

Behaviour:
- Reset is asynchronous and active-high; there is one clock domain (clk).

State and outputs during/after reset:
- rst forces state=IDLE, load_cnt=0, load_rd=0.
- In IDLE: enables=0, freeze1=freeze2=1, consume=0, flush=0, load_busy=0.
- IDLE moves to ISSUE on the first clk edge after rst deasserts.
- Issue outputs are combinational from registered state plus the inputs; state updates on posedge clk.

Decode (per slot):
- R-type 0110011: reads rs1 and rs2; writes rd.
- OP-IMM 0010011, LOAD 0000011, JALR 1100111: read rs1; write rd.
- STORE 0100011, BRANCH 1100011: read rs1 and rs2; write nothing.
- LUI, AUIPC, JAL: read nothing; write rd.
- Any other opcode: decoded as NOP (no reads, no writes), still consumed.
- Register x0 is never a hazard source or target.
- mem = LOAD or STORE. ctrl = BRANCH, JAL or JALR.

State ISSUE, slot 0 issues (datapath_1_enable=1) iff all hold:
- ins0_valid.
- No read of load_rd while load_cnt!=0.
- Not (LOAD while load_cnt!=0).

State ISSUE, slot 1 issues (datapath_2_enable=1) iff all hold:
- Slot 0 issues and ins1_valid.
- Slot 0 is not ctrl.
- Slot 1 is neither mem nor ctrl; only datapath 1 owns the memory port and PC.
- Slot 1 reads nothing slot 0 writes (RAW).
- Slot 1 rd does not equal slot 0 rd when both write, rd!=0 (WAW).
- Slot 1 passes the same load_cnt check as slot 0.

Freeze and consume:
- freeze1 = !datapath_1_enable; freeze2 = !datapath_2_enable.
- consume = datapath_1_enable + datapath_2_enable.

Load tracking:
- A load issuing at edge T captures load_rd and sets load_cnt=LOAD_LAT.
- load_cnt decrements each cycle while nonzero, in every state.
- A new load issue overrides the decrement.

Control flow:
- ctrl issuing in slot 0 sends ISSUE to BR_WAIT.
- BR_WAIT: enables=0, consume=0, freezes=1.
- BR_WAIT on branch_resolved & branch_taken goes to FLUSH. On branch_resolved & !branch_taken it goes to ISSUE.
- branch_resolved is ignored outside BR_WAIT.
- FLUSH lasts one cycle: flush=1, enables=0, consume=0, freezes=1, then ISSUE.
- An in-flight load is older than the branch and is not cancelled by FLUSH.

Reset mid-operation:
- Any state returns to IDLE immediately and the load scoreboard clears.

Decomposition:
- sched_pkg holds:
  - opcode localparams (OPC_R, OPC_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC)
  - the state enum (IDLE, ISSUE, BR_WAIT, FLUSH)
  - a decoded-instruction struct: rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd, is_mem, is_load, is_ctrl.
- Sub-module ins_class_decode: combinational, instantiated once per slot, fills that struct.

Test Plan:
1. Independent pair: ins0=00500093 (addi x1,x0,5), ins1=00700113 (addi x2,x0,7), both valid, ISSUE -> both enables=1, consume=2, freezes=0.
2. RAW pair: ins0=00500093, ins1=002081B3 (add x3,x1,x2) -> enable1=1, enable2=0, freeze2=1, consume=1.
3. Load-use: ins0=0000A203 (lw x4,0(x1)), ins1=004202B3 (add x5,x4,x4) -> lw issues alone; add (now slot 0) frozen for 2 cycles with load_busy=1, issues on 3rd cycle.
4. Memory port: ins0=00500093, ins1=0020A023 (sw x2,0(x1)) -> only slot 0 issues. The next cycle, with sw in slot 0, it issues.
5. Branch taken: ins0=00000463 (beq x0,x0,8) -> consume=1, then BR_WAIT with enables=0. Pulsing branch_resolved=1, branch_taken=1 gives flush=1 for exactly one cycle, then ISSUE. Repeating with branch_taken=0 gives no flush.
6. Reset: assert rst asynchronously mid-BR_WAIT with load_cnt=1 -> outputs immediately enables=0, freezes=1, load_busy=0. The first edge after release reaches ISSUE.
